// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - debounced push-button event classifier with an Avalon-MM event FIFO and IRQ
// Optional feature macro: BUTTON_LONG_PRESS_EN (hold counter, HELD state and LONG events).
module button_event_ctrl #(
   parameter int NUM_BUTTONS       = 4,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int LONG_PRESS_CYCLES = 50000000,
   parameter int FIFO_DEPTH        = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_BUTTONS-1:0] in_port,
   input  logic [1:0]             address,
   input  logic                   chipselect,
   input  logic                   read_n,
   input  logic                   write_n,
   input  logic [31:0]            writedata,
   output logic [31:0]            readdata,
   output logic                   irq
);

   localparam int IW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [1:0] EV_PRESS   = 2'b01;
   localparam logic [1:0] EV_RELEASE = 2'b10;
   localparam logic [1:0] EV_LONG    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESSED,
      ST_HELD
   } btn_state_t;

   logic [NUM_BUTTONS-1:0] sync_meta;
   logic [NUM_BUTTONS-1:0] pressed_sync;
   logic [DW-1:0]          deb_cnt [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] deb_state;
   logic [NUM_BUTTONS-1:0] deb_press;
   logic [NUM_BUTTONS-1:0] deb_release;

   btn_state_t             state      [NUM_BUTTONS];
   btn_state_t             state_next [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] raise;
   logic [1:0]             raise_type [NUM_BUTTONS];

   logic [NUM_BUTTONS-1:0] pend_valid;
   logic [1:0]             pend_type [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] grant_onehot;
   logic                   grant_valid;
   logic [IW-1:0]          grant_idx;
   logic [IW-1:0]          rr_ptr;
   logic                   pend_overwrite;

   logic [5:0]             fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [6:0]             count;
   logic                   fifo_full;
   logic                   fifo_nonempty;
   logic [5:0]             push_word;

   logic                   rd_strobe;
   logic                   wr_strobe;
   logic                   pop;
   logic                   do_push;
   logic                   drop;
   logic                   flush;
   logic                   ovf_clr;
   logic                   overflow;
   logic [1:0]             irq_mask;

   wire unused_wdata = &{1'b0, writedata[31:10], writedata[7:2]};

   // Two-flop synchroniser; stores the pressed sense so 1 means pressed downstream.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_meta    <= '0;
         pressed_sync <= '0;
      end else begin
         sync_meta    <= ~in_port;
         pressed_sync <= sync_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         deb_state   <= '0;
         deb_press   <= '0;
         deb_release <= '0;
         for (int i = 0; i < NUM_BUTTONS; i++) deb_cnt[i] <= '0;
      end else begin
         deb_press   <= '0;
         deb_release <= '0;
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (pressed_sync[i] == deb_state[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               deb_cnt[i]     <= '0;
               deb_state[i]   <= pressed_sync[i];
               deb_press[i]   <= pressed_sync[i];
               deb_release[i] <= ~pressed_sync[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

`ifdef BUTTON_LONG_PRESS_EN
   localparam int HW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;

   logic [HW-1:0]          hold_cnt [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] hold_done;

   // The hold counter only runs while a button sits in PRESSED; any other state parks it at zero.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_BUTTONS; i++) hold_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (state[i] != ST_PRESSED) hold_cnt[i] <= '0;
            else                        hold_cnt[i] <= hold_cnt[i] + HW'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_BUTTONS; i++)
         hold_done[i] = (hold_cnt[i] == HW'(LONG_PRESS_CYCLES - 1));
   end
`else
   localparam int unused_long_cycles = LONG_PRESS_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_BUTTONS; i++) state[i] <= ST_IDLE;
      end else begin
         for (int i = 0; i < NUM_BUTTONS; i++) state[i] <= state_next[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         state_next[i] = state[i];
         raise[i]      = 1'b0;
         raise_type[i] = EV_PRESS;
         case (state[i])
            ST_IDLE: begin
               if (deb_press[i]) begin
                  state_next[i] = ST_PRESSED;
                  raise[i]      = 1'b1;
                  raise_type[i] = EV_PRESS;
               end
            end
            ST_PRESSED: begin
               if (deb_release[i]) begin
                  state_next[i] = ST_IDLE;
                  raise[i]      = 1'b1;
                  raise_type[i] = EV_RELEASE;
               end
`ifdef BUTTON_LONG_PRESS_EN
               else if (hold_done[i]) begin
                  state_next[i] = ST_HELD;
                  raise[i]      = 1'b1;
                  raise_type[i] = EV_LONG;
               end
`endif
            end
            ST_HELD: begin
               if (deb_release[i]) begin
                  state_next[i] = ST_IDLE;
                  raise[i]      = 1'b1;
                  raise_type[i] = EV_RELEASE;
               end
            end
            default: state_next[i] = ST_IDLE;
         endcase
      end
   end

   // Round-robin search starting at rr_ptr; the first pending slot found wins this cycle.
   always_comb begin
      int            cand;
      logic [IW-1:0] cand_idx;
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < NUM_BUTTONS; k++) begin
         cand     = (int'(rr_ptr) + k) % NUM_BUTTONS;
         cand_idx = IW'(cand);
         if (!grant_valid && pend_valid[cand_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_BUTTONS; i++)
         grant_onehot[i] = grant_valid && (grant_idx == IW'(i));
   end

   assign pend_overwrite = |(raise & pend_valid & ~grant_onehot);
   assign push_word      = {pend_type[grant_idx], 1'b0, 3'(grant_idx)};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr     <= '0;
         pend_valid <= '0;
         for (int i = 0; i < NUM_BUTTONS; i++) pend_type[i] <= '0;
      end else begin
         if (grant_valid) begin
            if (grant_idx == IW'(NUM_BUTTONS - 1)) rr_ptr <= '0;
            else                                   rr_ptr <= grant_idx + IW'(1);
         end
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (raise[i]) begin
               pend_valid[i] <= 1'b1;
               pend_type[i]  <= raise_type[i];
            end else if (grant_onehot[i]) begin
               pend_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign rd_strobe     = chipselect & ~read_n;
   assign wr_strobe     = chipselect & ~write_n;
   assign fifo_nonempty = (count != 7'd0);
   assign fifo_full     = (count == 7'(FIFO_DEPTH));
   assign pop           = rd_strobe & (address == 2'd1) & fifo_nonempty;
   assign flush         = wr_strobe & (address == 2'd3) & writedata[9];
   assign ovf_clr       = wr_strobe & (address == 2'd3) & writedata[8];
   // A pop in the same cycle frees the slot the incoming event needs.
   assign do_push       = grant_valid & (~fifo_full | pop);
   assign drop          = grant_valid & fifo_full & ~pop & ~flush;

   always_ff @(posedge clk) begin
      if (do_push && !flush) fifo_mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !pop)      count <= count + 7'd1;
         else if (!do_push && pop) count <= count - 7'd1;
      end
   end

   // A lost event outranks a same-cycle software clear so it is never silently hidden.
   always_ff @(posedge clk) begin
      if (!reset_n)                   overflow <= 1'b0;
      else if (pend_overwrite || drop) overflow <= 1'b1;
      else if (ovf_clr)               overflow <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n)                              irq_mask <= 2'b00;
      else if (wr_strobe && address == 2'd2)     irq_mask <= writedata[1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (rd_strobe) begin
         case (address)
            2'd0:    readdata <= 32'(deb_state);
            2'd1:    readdata <= fifo_nonempty ? {1'b1, 25'd0, fifo_mem[rd_ptr]} : 32'd0;
            2'd2:    readdata <= {30'd0, irq_mask};
            default: readdata <= {23'd0, overflow, 1'b0, count};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) irq <= 1'b0;
      else          irq <= (irq_mask[0] & fifo_nonempty) | (irq_mask[1] & overflow);
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - directed scoreboard bench for button_event_ctrl
module tb_button_event_ctrl;

   localparam int NB  = 4;
   localparam int DC  = 16;
   localparam int LPC = 64;
   localparam int FD  = 4;

`ifdef BUTTON_LONG_PRESS_EN
   localparam int LONG_EVENTS = 3;
`else
   localparam int LONG_EVENTS = 2;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NB-1:0] in_port;
   logic [1:0]    address;
   logic          chipselect;
   logic          read_n;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          irq;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [31:0]   exp_q [$];

   always #5 clk = ~clk;

   button_event_ctrl #(
      .NUM_BUTTONS      (NB),
      .DEBOUNCE_CYCLES  (DC),
      .LONG_PRESS_CYCLES(LPC),
      .FIFO_DEPTH       (FD)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_port   (in_port),
      .address   (address),
      .chipselect(chipselect),
      .read_n    (read_n),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      read_n     = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      read_n     = 1'b1;
      d          = readdata;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
      address    = a;
      writedata  = wd;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      in_port = '1;
      idle(3);
      reset_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic pop_check(input string tag);
      logic [31:0] d;
      logic [31:0] e;
      bus_read(2'd1, d);
      e = (exp_q.size() == 0) ? 32'd0 : exp_q.pop_front();
      check(tag, d, e);
   endtask

   task automatic wait_count(input int n, input string tag);
      logic [31:0] d;
      d = '0;
      for (int i = 0; i < 200; i++) begin
         bus_read(2'd3, d);
         if (int'(d[6:0]) == n) break;
      end
      check(tag, 32'(d[6:0]), 32'(n));
   endtask

   initial begin
      logic [31:0] d;
      int          first_i;
      int          lat;

      reset_n    = 1'b0;
      in_port    = '1;
      address    = '0;
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      writedata  = '0;
      #1;

      // Reset state and register access.
      do_reset();
      check("rst_readdata", readdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      bus_read(2'd3, d);
      check("rst_addr3", d, 32'd0);
      bus_read(2'd0, d);
      check("rst_addr0", d, 32'd0);
      pop_check("rst_empty_pop");
      bus_read(2'd2, d);
      check("rst_mask", d, 32'd0);
      bus_write(2'd2, 32'hFFFF_FFFF);
      bus_read(2'd2, d);
      check("mask_rw", d, 32'd3);
      bus_write(2'd2, 32'd0);

      // Bounce filter on button 1.
      do_reset();
      for (int t = 0; t < 60; t++) begin
         if (t % 5 == 0) in_port[1] = ~in_port[1];
         idle(1);
      end
      in_port[1] = 1'b0;
      bus_read(2'd3, d);
      check("bounce_no_event", d, 32'd0);
      idle(19);
      exp_q.push_back(32'h8000_0011);
      wait_count(1, "bounce_count");
      bus_read(2'd0, d);
      check("bounce_deb_state", d, 32'h2);
      pop_check("bounce_press");
      pop_check("bounce_empty");

      // Long press on button 2.
      do_reset();
      in_port[2] = 1'b0;
      exp_q.push_back(32'h8000_0012);
`ifdef BUTTON_LONG_PRESS_EN
      exp_q.push_back(32'h8000_0032);
`endif
      idle(100);
      in_port[2] = 1'b1;
      exp_q.push_back(32'h8000_0022);
      wait_count(LONG_EVENTS, "long_count");
      for (int k = 0; k < LONG_EVENTS; k++) pop_check("long_event");
      pop_check("long_empty");

      // Simultaneous press of all buttons; also measures event latency.
      do_reset();
      in_port = '0;
      first_i = 0;
      d       = '0;
      for (int i = 1; i <= 60; i++) begin
         bus_read(2'd3, d);
         if (d[6:0] != 7'd0) begin
            first_i = i;
            break;
         end
      end
      check("sim_count1", 32'(d[6:0]), 32'd1);
      for (int k = 2; k <= 4; k++) begin
         bus_read(2'd3, d);
         check("sim_count_step", 32'(d[6:0]), 32'(k));
      end
      check("sim_irq_masked", 32'(irq), 32'd0);
      lat = (first_i > 2) ? first_i - 1 : 2;
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h8000_0010 | 32'(k));
      for (int k = 0; k < 4; k++) pop_check("sim_order");

      // Overflow and IRQ.
      do_reset();
      bus_write(2'd2, 32'd3);
      in_port[1] = 1'b0;
      wait_count(1, "ovf_fill1");
      in_port[1] = 1'b1;
      wait_count(2, "ovf_fill2");
      in_port[1] = 1'b0;
      wait_count(3, "ovf_fill3");
      in_port[1] = 1'b1;
      wait_count(4, "ovf_fill4");
      exp_q.push_back(32'h8000_0011);
      exp_q.push_back(32'h8000_0021);
      exp_q.push_back(32'h8000_0011);
      exp_q.push_back(32'h8000_0021);
      check("ovf_irq_nonempty", 32'(irq), 32'd1);
      in_port[0] = 1'b0;
      for (int i = 0; i < 200; i++) begin
         bus_read(2'd3, d);
         if (d[8]) break;
      end
      check("ovf_state", d, 32'h104);
      idle(1);
      check("ovf_irq", 32'(irq), 32'd1);
      bus_write(2'd3, 32'h300);
      exp_q.delete();
      bus_read(2'd3, d);
      check("flush_state", d, 32'd0);
      check("flush_irq", 32'(irq), 32'd0);
      pop_check("flush_empty");

      // Full FIFO with a pop landing on the grant cycle.
      do_reset();
      in_port = '0;
      wait_count(4, "full_fill");
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h8000_0010 | 32'(k));
      in_port[0] = 1'b1;
      idle(lat - 1);
      pop_check("full_pop_head");
      exp_q.push_back(32'h8000_0020);
      bus_read(2'd3, d);
      check("full_state", d, 32'h004);
      for (int k = 0; k < 4; k++) pop_check("full_drain");
      pop_check("full_empty");
      bus_read(2'd3, d);
      check("full_final_state", d, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
